// File: rtl/lbuf_pkg.sv
// Shared types and lane helpers for the lbuf local-buffer RAM.
package lbuf_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } lbuf_state_e;

  localparam int unsigned LBUF_MAX_WIDTH = 1024;
  localparam int unsigned LBUF_MAX_LANES = 128;
  localparam int unsigned LBUF_BIT_IW    = $clog2(LBUF_MAX_WIDTH);
  localparam int unsigned LBUF_LANE_IW   = $clog2(LBUF_MAX_LANES);

  function automatic int unsigned lane_width(input int unsigned width, input int unsigned lanes);
    return width / lanes;
  endfunction

  // Expand a lane mask into a per-bit mask; callers truncate to their word width.
  function automatic logic [LBUF_MAX_WIDTH-1:0] lane_bits(input logic [LBUF_MAX_LANES-1:0] mask,
                                                          input int unsigned width,
                                                          input int unsigned lw);
    logic [LBUF_MAX_WIDTH-1:0] bits;
    bits = '0;
    for (int unsigned b = 0; b < width; b++) begin
      bits[LBUF_BIT_IW'(b)] = mask[LBUF_LANE_IW'(b / lw)];
    end
    return bits;
  endfunction

endpackage

// File: rtl/lbuf_lane_merge.sv
// Lane-wise merge: masked lanes take new_word, the rest keep old_word.
module lbuf_lane_merge
  import lbuf_pkg::*;
#(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned LANES = 8
) (
  input  logic [WIDTH-1:0] old_word,
  input  logic [WIDTH-1:0] new_word,
  input  logic [LANES-1:0] mask,
  output logic [WIDTH-1:0] merged_c
);

  logic [WIDTH-1:0] bit_mask_c;

  assign bit_mask_c = WIDTH'(lane_bits(LBUF_MAX_LANES'(mask), WIDTH, lane_width(WIDTH, LANES)));
  assign merged_c   = (old_word & ~bit_mask_c) | (new_word & bit_mask_c);

endmodule

// File: rtl/lbuf_dp_ram.sv
// Dual-port lane-masked local buffer with write-through and A-priority collisions.
// Define LBUF_CLEAR_EN to zero the array with a post-reset sweep before READY.
module lbuf_dp_ram
  import lbuf_pkg::*;
#(
  parameter  int unsigned DEPTH = 72,
  parameter  int unsigned WIDTH = 128,
  parameter  int unsigned LANES = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             A_EN,
  input  logic [LANES-1:0] A_WE,
  input  logic [AW-1:0]    A_ADDR,
  input  logic [WIDTH-1:0] A_DI,
  output logic [WIDTH-1:0] A_DO,
  output logic             A_DV,
  input  logic             B_EN,
  input  logic [LANES-1:0] B_WE,
  input  logic [AW-1:0]    B_ADDR,
  input  logic [WIDTH-1:0] B_DI,
  output logic [WIDTH-1:0] B_DO,
  output logic             B_DV,
  output logic             READY,
  output logic             COLL
);

  if (WIDTH % LANES != 0 || WIDTH > LBUF_MAX_WIDTH || LANES > LBUF_MAX_LANES || DEPTH < 2)
  begin : g_cfg_err
    $error("lbuf_dp_ram: illegal DEPTH/WIDTH/LANES combination");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  logic             acc_a, acc_b, in_a, in_b, rd_a, rd_b, wr_a, wr_b, same_c;
  logic [AW-1:0]    idx_a, idx_b;
  logic [LANES-1:0] wa_c, wb_c, wa_same_c, wb_same_c;
  logic [WIDTH-1:0] wt_a_c, wt_b_c, a_word_c, b_word_c;
  logic             ready_nxt_c;

  // Requests are dropped while RST is high even if READY has not fallen yet.
  assign acc_a  = A_EN && READY && !RST;
  assign acc_b  = B_EN && READY && !RST;
  assign in_a   = 32'(A_ADDR) < DEPTH;
  assign in_b   = 32'(B_ADDR) < DEPTH;
  assign idx_a  = in_a ? A_ADDR : '0;
  assign idx_b  = in_b ? B_ADDR : '0;
  assign rd_a   = acc_a && (A_WE == '0);
  assign rd_b   = acc_b && (B_WE == '0);
  assign wr_a   = acc_a && (A_WE != '0) && in_a;
  assign wr_b   = acc_b && (B_WE != '0) && in_b;
  assign wa_c   = wr_a ? A_WE : '0;
  assign wb_c   = wr_b ? B_WE : '0;
  assign same_c = in_a && in_b && (A_ADDR == B_ADDR);
  assign wa_same_c = same_c ? wa_c : '0;
  assign wb_same_c = same_c ? wb_c : '0;

  // wt_a also serves as the base of A's write so shared lanes land B-under-A.
  lbuf_lane_merge #(.WIDTH(WIDTH), .LANES(LANES)) u_wt_a (
    .old_word(mem[idx_a]), .new_word(B_DI), .mask(wb_same_c), .merged_c(wt_a_c));
  lbuf_lane_merge #(.WIDTH(WIDTH), .LANES(LANES)) u_wt_b (
    .old_word(mem[idx_b]), .new_word(A_DI), .mask(wa_same_c), .merged_c(wt_b_c));
  lbuf_lane_merge #(.WIDTH(WIDTH), .LANES(LANES)) u_wr_a (
    .old_word(wt_a_c), .new_word(A_DI), .mask(wa_c), .merged_c(a_word_c));
  lbuf_lane_merge #(.WIDTH(WIDTH), .LANES(LANES)) u_wr_b (
    .old_word(mem[idx_b]), .new_word(B_DI), .mask(wb_c), .merged_c(b_word_c));

`ifdef LBUF_CLEAR_EN
  lbuf_state_e   state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;
  logic          clr_we_c;

  always_ff @(posedge CK) begin : p_state
    if (RST) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin : p_fsm
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_we_c    = 1'b0;
    case (state)
      CLEAR: begin
        clr_we_c = 1'b1;
        if (32'(clr_cnt) == DEPTH - 1) state_nxt = RUN;
        else                           clr_cnt_nxt = clr_cnt + AW'(1);
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  assign ready_nxt_c = (state_nxt == RUN);
`else
  assign ready_nxt_c = 1'b1;
`endif

  // B is written first so a same-address A write (already carrying B's lanes) wins.
  always_ff @(posedge CK) begin : p_mem
    if (!RST) begin
`ifdef LBUF_CLEAR_EN
      if (clr_we_c) mem[clr_cnt] <= '0;
`endif
      if (wr_b) mem[idx_b] <= b_word_c;
      if (wr_a) mem[idx_a] <= a_word_c;
    end
  end

  always_ff @(posedge CK) begin : p_out
    if (RST) begin
      A_DO  <= '0;
      B_DO  <= '0;
      A_DV  <= 1'b0;
      B_DV  <= 1'b0;
      COLL  <= 1'b0;
      READY <= 1'b0;
    end else begin
      READY <= ready_nxt_c;
      A_DV  <= rd_a;
      B_DV  <= rd_b;
      COLL  <= same_c && ((wa_c & wb_c) != '0);
      if (rd_a) A_DO <= in_a ? wt_a_c : '0;
      if (rd_b) B_DO <= in_b ? wt_b_c : '0;
    end
  end

endmodule

// File: tb/tb_lbuf_dp_ram.sv
// Randomised self-checking bench for lbuf_dp_ram against a lane-level array model.
module tb_lbuf_dp_ram;

  localparam int unsigned DEPTH = 72;
  localparam int unsigned WIDTH = 128;
  localparam int unsigned LANES = 8;
  localparam int unsigned LW    = WIDTH / LANES;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic             CK = 1'b0;
  logic             RST = 1'b1;
  logic             A_EN, B_EN, A_DV, B_DV, READY, COLL;
  logic [LANES-1:0] A_WE, B_WE;
  logic [AW-1:0]    A_ADDR, B_ADDR;
  logic [WIDTH-1:0] A_DI, B_DI, A_DO, B_DO;

  always #5 CK = ~CK;

  lbuf_dp_ram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LANES(LANES)) dut (
    .CK(CK), .RST(RST),
    .A_EN(A_EN), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_DI(A_DI), .A_DO(A_DO), .A_DV(A_DV),
    .B_EN(B_EN), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_DI(B_DI), .B_DO(B_DO), .B_DV(B_DV),
    .READY(READY), .COLL(COLL));

  int unsigned      n_checks = 0;
  int unsigned      n_fail   = 0;
  logic [WIDTH-1:0] model [DEPTH];
  logic             exp_ready = 1'b0;
  logic [WIDTH-1:0] exp_ado = '0, exp_bdo = '0;
  logic [WIDTH-1:0] d, o, da, db;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // What a read of addr sees: stored word, overlaid with the other port's same-cycle write lanes.
  function automatic logic [WIDTH-1:0] view(input logic [AW-1:0] addr, input logic [LANES-1:0] owe,
                                            input logic [AW-1:0] oaddr, input logic [WIDTH-1:0] odi);
    logic [WIDTH-1:0] w;
    w = model[addr];
    if (oaddr == addr)
      for (int l = 0; l < LANES; l++)
        if (owe[l]) w[l*LW +: LW] = odi[l*LW +: LW];
    return w;
  endfunction

  // One clock of stimulus; expectations come from the model, outputs sampled 1ns after the edge.
  task automatic cycle(input logic aen, input logic [LANES-1:0] awe, input logic [AW-1:0] aaddr,
                       input logic [WIDTH-1:0] adi,
                       input logic ben, input logic [LANES-1:0] bwe, input logic [AW-1:0] baddr,
                       input logic [WIDTH-1:0] bdi);
    logic acc_a, acc_b, in_a, in_b, exp_adv, exp_bdv, exp_coll;
    A_EN = aen; A_WE = awe; A_ADDR = aaddr; A_DI = adi;
    B_EN = ben; B_WE = bwe; B_ADDR = baddr; B_DI = bdi;
    acc_a = aen && exp_ready;
    acc_b = ben && exp_ready;
    in_a  = 32'(aaddr) < DEPTH;
    in_b  = 32'(baddr) < DEPTH;
    exp_adv = acc_a && (awe == '0);
    exp_bdv = acc_b && (bwe == '0);
    if (exp_adv) exp_ado = in_a ? view(aaddr, (acc_b && in_b) ? bwe : '0, baddr, bdi) : '0;
    if (exp_bdv) exp_bdo = in_b ? view(baddr, (acc_a && in_a) ? awe : '0, aaddr, adi) : '0;
    exp_coll = acc_a && acc_b && in_a && (aaddr == baddr) && ((awe & bwe) != '0);
    for (int l = 0; l < LANES; l++)
      if (acc_b && in_b && bwe[l]) model[baddr][l*LW +: LW] = bdi[l*LW +: LW];
    for (int l = 0; l < LANES; l++)
      if (acc_a && in_a && awe[l]) model[aaddr][l*LW +: LW] = adi[l*LW +: LW];
    @(posedge CK); #1;
    check("a_dv", WIDTH'(A_DV), WIDTH'(exp_adv));
    check("b_dv", WIDTH'(B_DV), WIDTH'(exp_bdv));
    check("a_do", A_DO, exp_ado);
    check("b_do", B_DO, exp_bdo);
    check("coll", WIDTH'(COLL), WIDTH'(exp_coll));
    check("ready", WIDTH'(READY), WIDTH'(exp_ready));
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset();
    RST = 1'b1; A_EN = 1'b0; B_EN = 1'b0;
    exp_ready = 1'b0; exp_ado = '0; exp_bdo = '0;
    repeat (2) @(posedge CK);
    #1;
    check("rst_a_do", A_DO, '0);
    check("rst_b_do", B_DO, '0);
    check("rst_a_dv", WIDTH'(A_DV), '0);
    check("rst_b_dv", WIDTH'(B_DV), '0);
    check("rst_coll", WIDTH'(COLL), '0);
    check("rst_ready", WIDTH'(READY), '0);
    RST = 1'b0;
  endtask

  task automatic wait_ready();
`ifdef LBUF_CLEAR_EN
    for (int c = 0; c < DEPTH; c++) begin
      check("clear_ready_low", WIDTH'(READY), '0);
      @(posedge CK); #1;
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
`else
    @(posedge CK); #1;
`endif
    check("ready_rise", WIDTH'(READY), WIDTH'(1));
    exp_ready = 1'b1;
  endtask

  task automatic sweep();
    for (int i = 0; i < DEPTH; i += 2)
      cycle(1'b1, '0, AW'(i), '0, 1'b1, '0, AW'(i + 1), '0);
  endtask

  initial begin
    A_EN = 1'b0; A_WE = '0; A_ADDR = '0; A_DI = '0;
    B_EN = 1'b0; B_WE = '0; B_ADDR = '0; B_DI = '0;
    do_reset();
    wait_ready();
`ifndef LBUF_CLEAR_EN
    for (int i = 0; i < DEPTH; i += 2)
      cycle(1'b1, '1, AW'(i), '0, 1'b1, '1, AW'(i + 1), '0);
`endif

    // Last word reads back zero with a one-cycle DV.
    cycle(1'b1, '0, AW'(71), '0, 1'b0, '0, '0, '0);
    check("rd71_do", A_DO, '0);
    check("rd71_dv", WIDTH'(A_DV), WIDTH'(1));

    // Full write then read on the other port next cycle.
    d = rnd_word();
    cycle(1'b1, 8'hFF, AW'(5), d, 1'b0, '0, '0, '0);
    cycle(1'b0, '0, '0, '0, 1'b1, '0, AW'(5), '0);
    check("wr5_b_do", B_DO, d);
    check("wr5_a_dv", WIDTH'(A_DV), '0);

    // Write-through: B reads while A writes the low four lanes.
    o = rnd_word();
    cycle(1'b1, 8'hFF, AW'(9), o, 1'b0, '0, '0, '0);
    d = rnd_word();
    cycle(1'b1, 8'h0F, AW'(9), d, 1'b1, '0, AW'(9), '0);
    check("wt9_b_do", B_DO, {o[127:64], d[63:0]});

    // Write-write collision: shared lane 1 goes to A.
    o = rnd_word();
    cycle(1'b1, 8'hFF, AW'(12), o, 1'b0, '0, '0, '0);
    da = rnd_word();
    db = rnd_word();
    cycle(1'b1, 8'h03, AW'(12), da, 1'b1, 8'h06, AW'(12), db);
    check("coll_pulse", WIDTH'(COLL), WIDTH'(1));
    cycle(1'b1, '0, AW'(12), '0, 1'b0, '0, '0, '0);
    check("coll_off", WIDTH'(COLL), '0);
    check("coll_word", A_DO, {o[127:48], db[47:32], da[31:0]});

    // Out-of-range read and write.
    cycle(1'b1, '0, AW'(80), '0, 1'b0, '0, '0, '0);
    check("oor_rd_do", A_DO, '0);
    check("oor_rd_dv", WIDTH'(A_DV), WIDTH'(1));
    cycle(1'b0, '0, '0, '0, 1'b1, 8'hFF, AW'(80), rnd_word());
    sweep();

    // Random traffic on both ports.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0]    aa, ba;
      logic [LANES-1:0] aw, bw;
      aa = AW'($urandom_range(0, DEPTH - 1));
      ba = ($urandom_range(0, 3) == 0) ? aa : AW'($urandom_range(0, DEPTH - 1));
      aw = ($urandom_range(0, 1) == 0) ? '0 : LANES'($urandom());
      bw = ($urandom_range(0, 1) == 0) ? '0 : LANES'($urandom());
      cycle($urandom_range(0, 3) != 0, aw, aa, rnd_word(),
            $urandom_range(0, 3) != 0, bw, ba, rnd_word());
    end
    sweep();

    // Reset during back-to-back reads at address 3.
    cycle(1'b1, '0, AW'(3), '0, 1'b1, '0, AW'(3), '0);
    A_EN = 1'b1; A_WE = '0; A_ADDR = AW'(3);
    B_EN = 1'b1; B_WE = '0; B_ADDR = AW'(3);
    RST  = 1'b1;
    @(posedge CK); #1;
    check("mid_rst_a_dv", WIDTH'(A_DV), '0);
    check("mid_rst_b_dv", WIDTH'(B_DV), '0);
    check("mid_rst_a_do", A_DO, '0);
    check("mid_rst_ready", WIDTH'(READY), '0);
    do_reset();
    wait_ready();
    idle();
    sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
